regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file with write-through bypass, per-register pending (scoreboard) bits and a hardware clear sequencer that runs after reset. It sits between decode (read addresses, destination reservation) and writeback in the pipeline. It generalises the fixed 2-read/1-write, 32×32 register file to configurable width, depth and read-port count. It adds deterministic zero-initialisation and hazard tracking.

---
 rtl/regfile_mp.sv | 115 +++++++++++
 tb/tb_regfile_mp.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write-through bypass,
// per-register pending bits and a clear sequencer that zeroes the array after reset.
module regfile_mp #(
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 32,
  parameter int  NUM_RD   = 2,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  output logic                     init_ready_o,
  input  logic                     we_i,
  input  logic [AW-1:0]            w_addr_i,
  input  logic [DATA_W-1:0]        w_data_i,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     rsv_valid_i,
  input  logic [AW-1:0]            rsv_addr_i
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

  state_t              state_reg, state_next;
  logic [AW-1:0]       cnt_reg, cnt_next;
  logic [NUM_REGS-1:0] pend_reg, pend_next;
  logic [DATA_W-1:0]   mem_reg [NUM_REGS];

  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                wr_ok;
  logic                rsv_ok;

  // x0 and addresses past the last register are never written, reserved or read.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < 32'(NUM_REGS));
  endfunction

  assign wr_ok        = we_i && addr_ok(w_addr_i);
  assign rsv_ok       = rsv_valid_i && addr_ok(rsv_addr_i);
  assign init_ready_o = (state_reg == READY);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= CLEAR;
      cnt_reg   <= AW'(1);
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    mem_we     = 1'b0;
    mem_waddr  = w_addr_i;
    mem_wdata  = w_data_i;
    case (state_reg)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_reg;
        mem_wdata = '0;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ADDR) state_next = READY;
      end
      READY: begin
        mem_we = wr_ok;
        if (wr_ok)  pend_next[w_addr_i]   = 1'b0;
        // Reservation applied last so a same-cycle new producer keeps the bit set.
        if (rsv_ok) pend_next[rsv_addr_i] = 1'b1;
      end
      default: state_next = CLEAR;
    endcase
  end

  // Array has no reset; contents are zeroed by the CLEAR walk instead.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_reg[mem_waddr] <= mem_wdata;
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign addr = rd_addr_i[gi*AW +: AW];

      always_comb begin
        data = '0;
        busy = 1'b0;
        if (state_reg == READY && addr_ok(addr)) begin
          if (BYPASS != 0 && we_i && w_addr_i == addr) begin
            data = w_data_i;
          end else begin
            data = mem_reg[addr];
            busy = pend_reg[addr];
          end
        end
      end

      assign rd_data_o[gi*DATA_W +: DATA_W] = data;
      assign rd_busy_o[gi]                  = busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default instance against a reference model,
// plus a no-bypass/24-register instance and a 64-bit/16-register/4-port instance.
module tb_regfile_mp;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic            we, rsv_valid, init_ready;
  logic [AW-1:0]   w_addr, rsv_addr;
  logic [DW-1:0]   w_data;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_busy;

  // 24 registers, no bypass
  logic        nb_we, nb_rsv_valid, nb_init_ready;
  logic [4:0]  nb_w_addr, nb_rsv_addr;
  logic [31:0] nb_w_data;
  logic [9:0]  nb_rd_addr;
  logic [63:0] nb_rd_data;
  logic [1:0]  nb_rd_busy;

  // 64-bit, 16 registers, 4 read ports
  logic         wd_we, wd_rsv_valid, wd_init_ready;
  logic [3:0]   wd_w_addr, wd_rsv_addr;
  logic [63:0]  wd_w_data;
  logic [15:0]  wd_rd_addr;
  logic [255:0] wd_rd_data;
  logic [3:0]   wd_rd_busy;

  regfile_mp u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .init_ready_o(init_ready),
    .we_i(we), .w_addr_i(w_addr), .w_data_i(w_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr)
  );

  regfile_mp #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(2), .BYPASS(0)) u_nb (
    .clk_i(clk), .rst_n_i(rst_n), .init_ready_o(nb_init_ready),
    .we_i(nb_we), .w_addr_i(nb_w_addr), .w_data_i(nb_w_data),
    .rd_addr_i(nb_rd_addr), .rd_data_o(nb_rd_data), .rd_busy_o(nb_rd_busy),
    .rsv_valid_i(nb_rsv_valid), .rsv_addr_i(nb_rsv_addr)
  );

  regfile_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4), .BYPASS(1)) u_wd (
    .clk_i(clk), .rst_n_i(rst_n), .init_ready_o(wd_init_ready),
    .we_i(wd_we), .w_addr_i(wd_w_addr), .w_data_i(wd_w_data),
    .rd_addr_i(wd_rd_addr), .rd_data_o(wd_rd_data), .rd_busy_o(wd_rd_busy),
    .rsv_valid_i(wd_rsv_valid), .rsv_addr_i(wd_rsv_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the default instance: edge count since reset, contents, pending flags.
  int          m_edges;
  bit          m_ready;
  logic [31:0] m_mem  [NR];
  bit          m_pend [NR];

  task automatic model_reset();
    m_edges = 0;
    m_ready = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == NR - 1) begin
        m_ready = 1;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      if (we && w_addr != 0) begin
        m_mem[w_addr]  = w_data;
        m_pend[w_addr] = 0;
      end
      if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1;
    end
  endtask

  function automatic void model_read(input logic [4:0] a, output logic [31:0] d, output logic b);
    if (!m_ready || a == 0) begin
      d = '0; b = 1'b0;
    end else if (we && w_addr == a) begin
      d = w_data; b = 1'b0;
    end else begin
      d = m_mem[a]; b = m_pend[a];
    end
  endfunction

  task automatic check_main(input string tag);
    logic [31:0] ed;
    logic        eb;
    chk({tag, " init_ready"}, 64'(init_ready), 64'(m_ready));
    for (int p = 0; p < 2; p++) begin
      model_read(rd_addr[p*AW +: AW], ed, eb);
      chk($sformatf("%s rd_data[%0d]", tag, p), 64'(rd_data[p*DW +: DW]), 64'(ed));
      chk($sformatf("%s rd_busy[%0d]", tag, p), 64'(rd_busy[p]), 64'(eb));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vecs [13];

  logic [63:0] wd_vals [4];
  logic [3:0]  wd_regs [4];

  initial begin
    // we, wa, wd, rsv, ra, r0, r1, exp0, exp1, exp busy {p1,p0}
    vecs[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'hDEADBEEF, 2'b00};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd0, 5'd3, 32'h0,        32'h0,        2'b00};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h0,        32'h0,        2'b01};
    vecs[5]  = '{1'b1, 5'd3, 32'h9,        1'b0, 5'd0, 5'd3, 5'd3, 32'h9,        32'h9,        2'b00};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd7, 32'h9,        32'hDEADBEEF, 2'b00};
    vecs[7]  = '{1'b1, 5'd3, 32'h55,       1'b1, 5'd3, 5'd3, 5'd3, 32'h55,       32'h55,       2'b00};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h55,       32'h55,       2'b11};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd3, 32'h0,        32'h55,       2'b10};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'h55,       2'b10};
    vecs[11] = '{1'b1, 5'd3, 32'h77,       1'b0, 5'd0, 5'd3, 5'd7, 32'h77,       32'hDEADBEEF, 2'b00};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h77,       32'h77,       2'b00};

    wd_vals[0] = 64'h0123456789ABCDEF; wd_regs[0] = 4'd1;
    wd_vals[1] = 64'hFEDCBA9876543210; wd_regs[1] = 4'd2;
    wd_vals[2] = 64'h00000000FFFFFFFF; wd_regs[2] = 4'd3;
    wd_vals[3] = 64'h8000000000000001; wd_regs[3] = 4'd15;

    rst_n = 1'b0;
    we = 1'b1; w_addr = 5'd5; w_data = 32'hFFFF_FFFF;
    rsv_valid = 1'b1; rsv_addr = 5'd5; rd_addr = {5'd7, 5'd5};
    nb_we = 1'b0; nb_w_addr = '0; nb_w_data = '0; nb_rsv_valid = 1'b0; nb_rsv_addr = '0;
    nb_rd_addr = {5'd3, 5'd3};
    wd_we = 1'b0; wd_w_addr = '0; wd_w_data = '0; wd_rsv_valid = 1'b0; wd_rsv_addr = '0;
    wd_rd_addr = {4'd1, 4'd2, 4'd3, 4'd4};
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check_main("reset");
    chk("reset nb init_ready", 64'(nb_init_ready), 64'h0);
    chk("reset nb rd_data", nb_rd_data, 64'h0);
    chk("reset wd init_ready", 64'(wd_init_ready), 64'h0);
    chk("reset wd rd_data[0]", wd_rd_data[63:0], 64'h0);
    $display("reset state checked");

    // Clear sequence; writes and reservations to x5 are offered while clearing.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      we        = (k < 31);
      rsv_valid = (k < 31);
      #1;
      chk($sformatf("clear k=%0d init_ready", k), 64'(init_ready), 64'(k >= 31));
      chk($sformatf("clear k=%0d nb init_ready", k), 64'(nb_init_ready), 64'(k >= 23));
      chk($sformatf("clear k=%0d wd init_ready", k), 64'(wd_init_ready), 64'(k >= 15));
      check_main($sformatf("clear k=%0d", k));
      tick();
    end
    $display("clear sequence: ready after %0d edges", m_edges);

    #1;
    chk("x5 after clear data", 64'(rd_data[31:0]), 64'h0);
    chk("x5 after clear busy", 64'(rd_busy[0]), 64'h0);
    for (int a = 1; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("cleared x%0d/x%0d", a, 31 - a), rd_data, 64'h0);
    end

    // Directed bypass / scoreboard vectors
    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; w_addr = vecs[i].wa; w_data = vecs[i].wd;
      rsv_valid = vecs[i].rsv; rsv_addr = vecs[i].ra;
      rd_addr = {vecs[i].r1, vecs[i].r0};
      #1;
      chk($sformatf("vec%0d rd_data[0]", i), 64'(rd_data[31:0]), 64'(vecs[i].e0));
      chk($sformatf("vec%0d rd_data[1]", i), 64'(rd_data[63:32]), 64'(vecs[i].e1));
      chk($sformatf("vec%0d rd_busy", i), 64'(rd_busy), 64'(vecs[i].eb));
      check_main($sformatf("vec%0d", i));
      $display("vec %0d: we=%0b wa=%0d rsv=%0b ra=%0d r0=x%0d->%h r1=x%0d->%h busy=%b",
               i, we, w_addr, rsv_valid, rsv_addr, vecs[i].r0, rd_data[31:0],
               vecs[i].r1, rd_data[63:32], rd_busy);
      tick();
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      we        = 1'($urandom_range(0, 1));
      w_addr    = 5'($urandom_range(0, 31));
      w_data    = $urandom;
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = 5'($urandom_range(0, 31));
      rd_addr   = {5'($urandom_range(0, 31)), (i % 3 == 0) ? w_addr : 5'($urandom_range(0, 31))};
      #1;
      check_main($sformatf("rand%0d", i));
      tick();
    end
    we = 1'b0; rsv_valid = 1'b0;
    $display("random phase: 400 transactions");

    // No-bypass instance: write becomes visible only after the edge
    nb_we = 1'b1; nb_w_addr = 5'd10; nb_w_data = 32'hA5A50001; nb_rd_addr = {5'd10, 5'd10};
    #1;
    chk("nb write same cycle", nb_rd_data, 64'h0);
    tick();
    nb_we = 1'b0;
    #1;
    chk("nb write after edge", nb_rd_data, 64'hA5A50001_A5A50001);
    $display("nb: x10 write -> %h", nb_rd_data[31:0]);

    // Out-of-range write and reserve are dropped
    nb_we = 1'b1; nb_w_addr = 5'd30; nb_w_data = 32'hBAD0BAD0;
    nb_rsv_valid = 1'b1; nb_rsv_addr = 5'd30; nb_rd_addr = {5'd6, 5'd30};
    #1;
    chk("nb oor same cycle", nb_rd_data, 64'h0);
    tick();
    nb_we = 1'b0; nb_rsv_valid = 1'b0;
    #1;
    chk("nb oor read x30/x6", nb_rd_data, 64'h0);
    chk("nb oor busy", 64'(nb_rd_busy), 64'h0);
    nb_rd_addr = {5'd22, 5'd14};
    #1;
    chk("nb oor x14/x22", nb_rd_data, 64'h0);
    nb_rd_addr = {5'd10, 5'd10};
    #1;
    chk("nb x10 kept", nb_rd_data, 64'hA5A50001_A5A50001);
    $display("nb: out-of-range write to 30 dropped");

    // No-bypass scoreboard: busy stays visible during the write cycle
    nb_rsv_valid = 1'b1; nb_rsv_addr = 5'd12; nb_rd_addr = {5'd12, 5'd12};
    tick();
    nb_rsv_valid = 1'b0;
    #1;
    chk("nb x12 reserved busy", 64'(nb_rd_busy), 64'h3);
    nb_we = 1'b1; nb_w_addr = 5'd12; nb_w_data = 32'h12;
    #1;
    chk("nb x12 write cycle data", nb_rd_data, 64'h0);
    chk("nb x12 write cycle busy", 64'(nb_rd_busy), 64'h3);
    tick();
    nb_we = 1'b0;
    #1;
    chk("nb x12 after write data", nb_rd_data, 64'h00000012_00000012);
    chk("nb x12 after write busy", 64'(nb_rd_busy), 64'h0);
    $display("nb: x12 reserve/write -> %h busy=%b", nb_rd_data[31:0], nb_rd_busy);

    // Wide instance: four distinct registers read concurrently
    for (int i = 0; i < 4; i++) begin
      wd_we = 1'b1; wd_w_addr = wd_regs[i]; wd_w_data = wd_vals[i];
      wd_rd_addr = {4'd0, 4'd0, 4'd0, wd_regs[i]};
      #1;
      chk($sformatf("wd bypass x%0d", wd_regs[i]), wd_rd_data[63:0], wd_vals[i]);
      tick();
    end
    wd_we = 1'b0;
    wd_rd_addr = {wd_regs[3], wd_regs[2], wd_regs[1], wd_regs[0]};
    #1;
    for (int p = 0; p < 4; p++)
      chk($sformatf("wd port%0d x%0d", p, wd_regs[p]), wd_rd_data[p*64 +: 64], wd_vals[p]);
    chk("wd busy", 64'(wd_rd_busy), 64'h0);
    wd_rd_addr = {4'd3, 4'd3, 4'd3, 4'd3};
    #1;
    for (int p = 0; p < 4; p++)
      chk($sformatf("wd shared port%0d", p), wd_rd_data[p*64 +: 64], wd_vals[2]);
    $display("wd: 4-port concurrent reads done");

    // Reset in the middle of operation
    we = 1'b1; w_addr = 5'd4; w_data = 32'h3;
    tick();
    we = 1'b0; rsv_valid = 1'b1; rsv_addr = 5'd6;
    tick();
    rsv_valid = 1'b0; rd_addr = {5'd6, 5'd4};
    #1;
    chk("pre-reset x4", 64'(rd_data[31:0]), 64'h3);
    chk("pre-reset x6 busy", 64'(rd_busy[1]), 64'h1);
    check_main("pre-reset");
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid reset init_ready", 64'(init_ready), 64'h0);
    chk("mid reset rd_data", rd_data, 64'h0);
    chk("mid reset rd_busy", 64'(rd_busy), 64'h0);
    chk("mid reset wd init_ready", 64'(wd_init_ready), 64'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      #1;
      chk($sformatf("re-clear k=%0d init_ready", k), 64'(init_ready), 64'(k >= 31));
      tick();
    end
    #1;
    chk("post-reset x4", 64'(rd_data[31:0]), 64'h0);
    chk("post-reset x6 busy", 64'(rd_busy[1]), 64'h0);
    check_main("post-reset");
    $display("reset mid-operation: x4=%h x6 busy=%b", rd_data[31:0], rd_busy[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
